// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified memory arbiter: default widths, the
// starvation limit for instruction fetch, the arbiter FSM state encoding and
// the grantee encoding recorded when an access is latched.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_prio.sv
// -----------------------------------------------------------------------------
// mem_arb_prio
// Winner selection between the fetch and data requesters. Data normally wins;
// once fetch has lost MAX_WAIT contests in a row it is given the grant so it
// cannot be starved by a data stage that keeps re-requesting.
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_arb_en       : high when the arbiter is able to accept a new access
//   i_if_req       : fetch request
//   i_d_req        : data request
//   o_req_any      : at least one request is present
//   o_gnt_data     : 1 = data wins, 0 = fetch wins (meaningful with o_req_any)
// -----------------------------------------------------------------------------
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_arb_en,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_req_any,
  output logic o_gnt_data
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_starved;

  // Fetch is starved once it has lost MAX_WAIT contests back to back; in
  // that case a simultaneous data request is made to wait instead.
  assign w_starved  = (r_wait_cnt == CNT_W'(MAX_WAIT));
  assign o_gnt_data = i_d_req & ~(i_if_req & w_starved);
  assign o_req_any  = i_if_req | i_d_req;

  // The lost-contest counter only moves when a grant is actually taken.
  // A fetch grant clears it; a contested data win bumps it (it can never
  // exceed MAX_WAIT because a starved fetch always wins the next contest).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (i_arb_en) begin
      if (i_if_req & ~o_gnt_data) begin
        r_wait_cnt <= '0;
      end else if (i_if_req & i_d_req & ~w_starved) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory between the instruction fetch stage and the
// data stage. Each access takes three cycles: IDLE (arbitrate and latch the
// winner), ISSUE (one-cycle memory strobe) and RESP (one-cycle ack with read
// data taken straight from the memory, then held in a register).
//
// Ports
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_if_req, i_if_addr        : fetch request and address
//   o_if_rdata, o_if_ack       : fetched word and completion pulse
//   i_d_req, i_d_we, i_d_addr  : data request, write flag and address
//   i_d_wdata, i_d_be          : store data and byte enables
//   o_d_rdata, o_d_ack         : load data and completion pulse
//   o_mem_en, o_mem_we         : memory strobe and write enable
//   o_mem_addr, o_mem_wdata    : memory address and write data
//   o_mem_be                   : memory byte enables
//   i_mem_rdata                : memory read data, valid the cycle after strobe
//   o_stall_if, o_stall_mem    : stall requests back to the pipeline
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_ack,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_be,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_d_ack,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_stall_if,
  output logic                o_stall_mem
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  grant_e            r_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_arb_en;
  logic              w_req_any;
  logic              w_gnt_data;

  assign w_arb_en = (r_state == IDLE);

  mem_arb_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_arb_en   (w_arb_en),
    .i_if_req   (i_if_req),
    .i_d_req    (i_d_req),
    .o_req_any  (w_req_any),
    .o_gnt_data (w_gnt_data)
  );

  // State register. Reset drops straight back to IDLE, which also removes
  // the memory strobe and any ack in the same instant since both are decoded
  // from the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and memory/ack decode. Everything defaults to zero so the
  // memory bus is quiet outside ISSUE and acks only appear in RESP.
  always_comb begin
    w_state_next = r_state;
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_be     = '0;
    o_if_ack     = 1'b0;
    o_d_ack      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_any) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_state_next = RESP;
        o_mem_en     = 1'b1;
        o_mem_we     = r_we;
        o_mem_addr   = r_addr;
        o_mem_wdata  = r_wdata;
        o_mem_be     = r_be;
      end
      RESP: begin
        w_state_next = IDLE;
        o_if_ack     = (r_gnt == GNT_FETCH);
        o_d_ack      = (r_gnt == GNT_DATA);
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Capture the winning request in IDLE. Once captured the access runs to
  // completion regardless of what the requester does with its req line.
  // Fetches and loads always use the full word, so their byte enables are
  // stored as all-ones here rather than decoded later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt   <= GNT_FETCH;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_arb_en && w_req_any) begin
      if (w_gnt_data) begin
        r_gnt   <= GNT_DATA;
        r_addr  <= i_d_addr;
        r_we    <= i_d_we;
        r_wdata <= i_d_wdata;
        r_be    <= i_d_we ? i_d_be : '1;
      end else begin
        r_gnt   <= GNT_FETCH;
        r_addr  <= i_if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_be    <= '1;
      end
    end
  end

  // Read data arrives from the memory during RESP. It is passed straight
  // through while the ack is high and stored at the end of RESP so the
  // requester keeps seeing it afterwards. Stores never touch the load data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (r_state == RESP) begin
      if (r_gnt == GNT_FETCH) begin
        r_if_rdata <= i_mem_rdata;
      end else if (!r_we) begin
        r_d_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_if_rdata  = o_if_ack ? i_mem_rdata : r_if_rdata;
  assign o_d_rdata   = (o_d_ack && !r_we) ? i_mem_rdata : r_d_rdata;
  assign o_stall_if  = i_if_req & ~o_if_ack;
  assign o_stall_mem = i_d_req & ~o_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of single transactions with
// hand-computed results, hand-written sequences for contention, a late data
// pulse and mid-access reset, then random traffic against a transaction-level
// model of the arbiter and a sparse memory model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [3:0]  dBe;
  logic [31:0] memRdata;

  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic        o_if_ack, o_d_ack, o_mem_en, o_mem_we, o_stall_if, o_stall_mem;
  logic [3:0]  o_mem_be;

  int total = 0;
  int bad   = 0;

  // Clock generation, 10 time-unit period
  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MAXW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_if_req    (ifReq),
    .i_if_addr   (ifAddr),
    .o_if_rdata  (o_if_rdata),
    .o_if_ack    (o_if_ack),
    .i_d_req     (dReq),
    .i_d_we      (dWe),
    .i_d_addr    (dAddr),
    .i_d_wdata   (dWdata),
    .i_d_be      (dBe),
    .o_d_rdata   (o_d_rdata),
    .o_d_ack     (o_d_ack),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_be    (o_mem_be),
    .i_mem_rdata (memRdata),
    .o_stall_if  (o_stall_if),
    .o_stall_mem (o_stall_mem)
  );

  // Sparse memory; unwritten words read back as a pattern derived from
  // their address so every location is distinguishable
  logic [31:0] memArr [logic [31:0]];

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return a ^ 32'hC0DE0000;
  endfunction

  function automatic void memWrite(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] be);
    logic [31:0] w;
    w = memRead(a);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
    end
    memArr[a] = w;
  endfunction

  // Transaction-level model: which access is in flight and how far along,
  // how many contests fetch has lost in a row, and the last read data
  int          mPhase;
  bit          mGntData;
  logic [31:0] mAddr, mWdata;
  bit          mWe;
  logic [3:0]  mBe;
  int          mWait;
  logic [31:0] mIfRdata, mDRdata;
  logic [31:0] pendRdata;

  bit eIfAck, eDAck;
  int memEnCount;
  bit ackLog[$];

  task automatic modelReset();
    mPhase   = 0;
    mGntData = 0;
    mAddr    = '0;
    mWdata   = '0;
    mWe      = 0;
    mBe      = '0;
    mWait    = 0;
    mIfRdata = '0;
    mDRdata  = '0;
  endtask

  // Advance the model across one rising edge using the inputs seen there
  task automatic modelEdge();
    pendRdata = memRdata;
    if (!rst_n) return;
    if (mPhase == 0) begin
      if (ifReq || dReq) begin
        mGntData = dReq && !(ifReq && mWait == MAXW);
        if (mGntData) begin
          mAddr  = dAddr;
          mWe    = dWe;
          mWdata = dWdata;
          mBe    = dWe ? dBe : 4'hF;
          if (ifReq) mWait = (mWait + 1 > MAXW) ? MAXW : mWait + 1;
        end else begin
          mAddr  = ifAddr;
          mWe    = 0;
          mWdata = '0;
          mBe    = 4'hF;
          mWait  = 0;
        end
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (mWe) memWrite(mAddr, mWdata, mBe);
      else     pendRdata = memRead(mAddr);
      mPhase = 2;
    end else begin
      if (!mGntData)  mIfRdata = memRdata;
      else if (!mWe)  mDRdata  = memRdata;
      mPhase = 0;
    end
  endtask

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Compare every output against the model for the current cycle
  task automatic checkOutput();
    bit          eMemEn;
    logic [31:0] eIfRdata, eDRdata;
    eMemEn   = (mPhase == 1);
    eIfAck   = (mPhase == 2) && !mGntData;
    eDAck    = (mPhase == 2) && mGntData;
    eIfRdata = eIfAck ? memRdata : mIfRdata;
    eDRdata  = (eDAck && !mWe) ? memRdata : mDRdata;
    chk("mem_en",    32'(o_mem_en),    32'(eMemEn));
    chk("mem_we",    32'(o_mem_we),    32'(eMemEn && mWe));
    chk("mem_addr",  o_mem_addr,       eMemEn ? mAddr : 32'h0);
    chk("mem_wdata", o_mem_wdata,      eMemEn ? mWdata : 32'h0);
    chk("mem_be",    32'(o_mem_be),    eMemEn ? 32'(mBe) : 32'h0);
    chk("if_ack",    32'(o_if_ack),    32'(eIfAck));
    chk("d_ack",     32'(o_d_ack),     32'(eDAck));
    chk("if_rdata",  o_if_rdata,       eIfRdata);
    chk("d_rdata",   o_d_rdata,        eDRdata);
    chk("stall_if",  32'(o_stall_if),  32'(ifReq && !eIfAck));
    chk("stall_mem", 32'(o_stall_mem), 32'(dReq && !eDAck));
    chk("ack_excl",  32'(o_if_ack && o_d_ack), 32'h0);
    if (o_mem_en) memEnCount++;
    if (o_d_ack)  ackLog.push_back(1'b1);
    if (o_if_ack) ackLog.push_back(1'b0);
  endtask

  // One clock: model follows the edge, memory answers, then outputs checked
  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    memRdata = pendRdata;
    #1;
    checkOutput();
  endtask

  typedef struct {
    bit          ifReq;
    logic [31:0] ifAddr;
    bit          dReq;
    bit          dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dBe;
    bit          expData;
    logic [31:0] expMemAddr;
    bit          expMemWe;
    logic [3:0]  expMemBe;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[8];

  task automatic applyStimulus(input vec_t v);
    ifReq  = v.ifReq;
    ifAddr = v.ifAddr;
    dReq   = v.dReq;
    dWe    = v.dWe;
    dAddr  = v.dAddr;
    dWdata = v.dWdata;
    dBe    = v.dBe;
  endtask

  bit expPattern[10];
  int guard;

  initial begin
    //             ifReq ifAddr  dReq dWe dAddr   dWdata        dBe   data addr   we be    rdata
    vecs[0] = '{1, 32'h10, 0, 0, 32'h00, 32'h0,        4'h0, 0, 32'h10, 0, 4'hF, 32'h00500093};
    vecs[1] = '{0, 32'h00, 1, 1, 32'h40, 32'hDEADBEEF, 4'h3, 1, 32'h40, 1, 4'h3, 32'h00000000};
    vecs[2] = '{0, 32'h00, 1, 0, 32'h40, 32'h0,        4'h0, 1, 32'h40, 0, 4'hF, 32'hC0DEBEEF};
    vecs[3] = '{1, 32'h20, 1, 0, 32'h44, 32'h0,        4'h0, 1, 32'h44, 0, 4'hF, 32'hC0DE0044};
    vecs[4] = '{1, 32'h24, 0, 0, 32'h00, 32'h0,        4'h0, 0, 32'h24, 0, 4'hF, 32'hC0DE0024};
    vecs[5] = '{1, 32'h28, 1, 1, 32'h48, 32'h11223344, 4'hC, 1, 32'h48, 1, 4'hC, 32'hC0DE0044};
    vecs[6] = '{0, 32'h00, 1, 0, 32'h48, 32'h0,        4'h0, 1, 32'h48, 0, 4'hF, 32'h11220048};
    vecs[7] = '{1, 32'h10, 0, 0, 32'h00, 32'h0,        4'h0, 0, 32'h10, 0, 4'hF, 32'h00500093};
    expPattern = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    rst_n  = 1'b0;
    ifReq  = 0; ifAddr = '0;
    dReq   = 0; dWe = 0; dAddr = '0; dWdata = '0; dBe = '0;
    memRdata = '0;
    memEnCount = 0;
    memArr[32'h10] = 32'h00500093;
    modelReset();

    $display("[TB] reset state");
    #2 checkOutput();
    #10 rst_n = 1'b1;

    $display("[TB] single-transaction table");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v]);
      tick();
      chk("vec_issue_en",  32'(o_mem_en), 32'h1);
      chk("vec_issue_addr", o_mem_addr, vecs[v].expMemAddr);
      chk("vec_issue_we",  32'(o_mem_we), 32'(vecs[v].expMemWe));
      chk("vec_issue_be",  32'(o_mem_be), 32'(vecs[v].expMemBe));
      tick();
      if (vecs[v].expData) begin
        chk("vec_d_ack",   32'(o_d_ack), 32'h1);
        chk("vec_d_rdata", o_d_rdata, vecs[v].expRdata);
      end else begin
        chk("vec_if_ack",   32'(o_if_ack), 32'h1);
        chk("vec_if_rdata", o_if_rdata, vecs[v].expRdata);
      end
      ifReq = 0;
      dReq  = 0;
      tick();
    end

    $display("[TB] contention: both held for ten accesses");
    ackLog.delete();
    ifReq = 1; ifAddr = 32'h30;
    dReq = 1; dWe = 0; dAddr = 32'h50;
    guard = 0;
    while (ackLog.size() < 10 && guard < 60) begin
      tick();
      guard++;
    end
    ifReq = 0;
    dReq  = 0;
    chk("contention_timeout", 32'(ackLog.size() >= 10), 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i < ackLog.size()) chk("contention_order", 32'(ackLog[i]), 32'(expPattern[i]));
    end
    tick();

    $display("[TB] data pulse during fetch response");
    ifReq = 1; ifAddr = 32'h14;
    tick();
    tick();
    chk("pulse_if_ack", 32'(o_if_ack), 32'h1);
    ifReq = 0;
    dReq = 1; dWe = 0; dAddr = 32'h4C;
    memEnCount = 0;
    tick();
    dReq = 0;
    repeat (4) tick();
    chk("pulse_no_access", 32'(memEnCount), 32'h0);

    $display("[TB] reset during issue");
    dReq = 1; dWe = 0; dAddr = 32'h44;
    tick();
    chk("rst_pre_issue", 32'(o_mem_en), 32'h1);
    ackLog.delete();
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkOutput();
    dReq = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_no_ack", 32'(ackLog.size()), 32'h0);
    dReq = 1; dWe = 0; dAddr = 32'h48;
    tick();
    tick();
    chk("rst_resume_ack",   32'(o_d_ack), 32'h1);
    chk("rst_resume_rdata", o_d_rdata, 32'h11220048);
    dReq = 0;
    tick();

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      tick();
      if (eIfAck) ifReq = 0;
      if (eDAck)  dReq  = 0;
      if (!ifReq && $urandom_range(0, 2) == 0) begin
        ifReq  = 1;
        ifAddr = 32'($urandom_range(0, 15)) << 2;
      end else if (ifReq && $urandom_range(0, 11) == 0) begin
        ifReq = 0;
      end
      if (!dReq && $urandom_range(0, 2) == 0) begin
        dReq   = 1;
        dWe    = 1'($urandom_range(0, 1));
        dAddr  = 32'($urandom_range(0, 15)) << 2;
        dWdata = $urandom;
        dBe    = 4'($urandom_range(0, 15));
      end else if (dReq && $urandom_range(0, 11) == 0) begin
        dReq = 0;
      end
    end
    ifReq = 0;
    dReq  = 0;
    repeat (4) tick();

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports.
REQ-003 Parameter: MAX_WAIT, 4, number of consecutive lost contests after which fetch wins.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 if_req  input  1  instruction fetch request; held high until if_ack.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_rdata  output  DATA_W  fetched instruction; valid while if_ack=1.
REQ-009 if_ack  output  1  one-cycle completion pulse for fetch.
REQ-010 d_req, d_we  input  1 each  data-stage request; d_we=1 means write. d_req is held high until d_ack.
REQ-011 d_addr  input  ADDR_W  data address.
REQ-012 d_wdata  input  DATA_W  store data.
REQ-013 d_be  input  DATA_W/8  store byte enables.
REQ-014 d_rdata  output  DATA_W  load data; valid while d_ack=1 for reads.
REQ-015 d_ack  output  1  one-cycle completion pulse for data access.
REQ-016 mem_en, mem_we  output  1 each  unified memory strobe and write enable.
REQ-017 mem_addr  output  ADDR_W  memory address.
REQ-018 mem_wdata  output  DATA_W  memory write data.
REQ-019 mem_be  output  DATA_W/8  memory byte enables.
REQ-020 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en.
REQ-021 stall_if, stall_mem  output  1 each  pipeline stall requests.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE and RESP; IDLE->ISSUE on any sampled request, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-023 In IDLE the winner's addr/we/wdata/be SHALL be latched and the grantee recorded; no request means stay in IDLE.
REQ-024 Arbitration: data wins over fetch unless wait_cnt==MAX_WAIT, in which case fetch wins.
REQ-025 wait_cnt SHALL increment (saturating at MAX_WAIT) when both request and data wins, reset to 0 when fetch is granted, and hold otherwise.
REQ-026 In ISSUE, mem_en=1 for exactly one cycle; all mem_* are driven from latched values; mem_be=all-ones for fetches and reads; otherwise mem_* = 0.
REQ-027 In RESP, the grantee's ack=1 for exactly one cycle; rdata=mem_rdata is captured into a register for reads and fetches; writes leave d_rdata unchanged.
REQ-028 Latency: request sampled at edge N gives mem_en high in cycle N+1 and ack high in cycle N+2; peak throughput is one access per 3 cycles.
REQ-029 A request dropped before it is latched SHALL cause no access; once latched, the access SHALL complete and ack even if req falls.
REQ-030 Requests sampled in ISSUE/RESP SHALL be ignored; arbitration occurs only in IDLE.
REQ-031 stall_if = if_req & ~if_ack; stall_mem = d_req & ~d_ack, combinational.
REQ-032 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-033 On rst=0, asynchronously: state=IDLE, wait_cnt=0, all mem_*, acks and rdata registers = 0.
REQ-034 Reset mid-access SHALL abort with no ack and no further mem_en; after release, operation resumes from IDLE.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum and default values of ADDR_W, DATA_W and MAX_WAIT.
REQ-036 Winner selection and wait_cnt SHALL be one sub-module, mem_arb_prio; the FSM and latches stay in mem_arbiter.

Verification
REQ-037 Fetch-only: if_req=1, if_addr=0x10, mem_rdata=0x00500093 -> mem_en at N+1 with mem_addr=0x10, if_ack at N+2 with if_rdata=0x00500093.
REQ-038 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0x3 -> mem_we=1 and mem_be=0x3 in ISSUE, d_ack at N+2, d_rdata unchanged.
REQ-039 Contention: if_req and d_req both held high, with data re-requested after each ack -> the data request is served 4 times, then 1 fetch, with wait_cnt returning to 0.
REQ-040 Simultaneous single requests -> data is served first and fetch second; if_ack and d_ack are never coincident; stall_if is high until its ack.
REQ-041 Assert rst=0 during ISSUE -> no ack, mem_en=0 immediately; the next request after release completes normally.
REQ-042 d_req pulsed for one cycle during RESP of a fetch -> no data access is generated.
